// File: rtl/rf_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// rf_fifo_ctrl : FIFO controller for an external 2-port register file
// Optional sticky ovf/udf error flags enabled by macro RF_FIFO_CTRL_ERR_EN
// Rev 1.0
// ============================================================================
module rf_fifo_ctrl #(
    parameter int AW       = 10,
    parameter int DW       = 8,
    parameter int AF_LEVEL = 2**AW - 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          pop_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic          udf,
    input  logic          err_clr,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          wr_me_en,
    output logic [AW-1:0] rd_addr,
    output logic          rd_me_en,
    input  logic [DW-1:0] rd_data
);

    localparam logic [AW:0] C_DEPTH_CNT = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] C_AF_CNT    = AF_LEVEL[AW:0];

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [AW:0] count_q, count_d;
    logic        pop_valid_q;
    logic        w_push_ok;
    logic        w_pop_ok;

    assign full        = (count_q == C_DEPTH_CNT);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= C_AF_CNT);
    assign count       = count_q;

    // Acceptance is gated by rst so the RF strobes drop combinationally in reset.
    assign w_push_ok = push & ~full & ~rst;
    assign w_pop_ok  = pop & ~empty & ~rst;

    assign wr_me_en  = w_push_ok;
    assign wr_addr   = wptr_q[AW-1:0];
    assign wr_data   = push_data;
    assign rd_me_en  = w_pop_ok;
    assign rd_addr   = rptr_q[AW-1:0];
    assign pop_valid = pop_valid_q;
    assign pop_data  = rd_data;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (w_push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (w_pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (w_push_ok && !w_pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (w_pop_ok && !w_push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            pop_valid_q <= w_pop_ok;
        end
    end

`ifdef RF_FIFO_CTRL_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // A set event wins over a simultaneous clear.
    always_comb begin
        ovf_d = (push & full) | (ovf_q & ~err_clr);
        udf_d = (pop & empty) | (udf_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign ovf            = 1'b0;
    assign udf            = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rf_fifo_ctrl : scoreboard bench for rf_fifo_ctrl (AW=2, DW=8, AF_LEVEL=3)
// Rev 1.0
// ============================================================================
module tb_rf_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst, push, pop, err_clr;
    logic [7:0] push_data, pop_data, wr_data, rd_data;
    logic       pop_valid, full, empty, almost_full, ovf, udf;
    logic [2:0] count;
    logic [1:0] wr_addr, rd_addr;
    logic       wr_me_en, rd_me_en;

    rf_fifo_ctrl #(.AW(2), .DW(8), .AF_LEVEL(3)) dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data),
        .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid),
        .full(full), .empty(empty), .almost_full(almost_full), .count(count),
        .ovf(ovf), .udf(udf), .err_clr(err_clr),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_me_en(wr_me_en),
        .rd_addr(rd_addr), .rd_me_en(rd_me_en), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Register-file model: registered read address, combinational read data.
    logic [7:0] rf_mem [4];
    logic [1:0] rf_raddr_q = 2'd0;
    always @(posedge clk) begin
        if (wr_me_en) rf_mem[wr_addr] <= wr_data;
        if (rd_me_en) rf_raddr_q <= rd_addr;
    end
    assign rd_data = rf_mem[rf_raddr_q];

    int         n_checks = 0;
    int         n_err    = 0;
    logic [2:0] m_wptr = '0, m_rptr = '0;
    int         m_count = 0;
    bit         m_pv = 0, m_ovf = 0, m_udf = 0;
    logic [7:0] q_data[$];
    logic [7:0] q_exp[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock: drive after negedge, check strobes, clock, check registered state.
    task automatic step(input bit p, input logic [7:0] d, input bit q, input bit r, input bit c);
        bit         e_push, e_pop;
        logic [7:0] e;
        push = p; push_data = d; pop = q; rst = r; err_clr = c;
        #1;
        e_push = p && !r && (m_count != 4);
        e_pop  = q && !r && (m_count != 0);
        chk("wr_me_en", wr_me_en, e_push);
        chk("rd_me_en", rd_me_en, e_pop);
        if (e_push) begin
            chk("wr_addr", wr_addr, m_wptr[1:0]);
            chk("wr_data", wr_data, d);
        end
        if (e_pop) chk("rd_addr", rd_addr, m_rptr[1:0]);

        if (r) begin
            m_wptr = '0; m_rptr = '0; m_count = 0; m_pv = 0;
            m_ovf = 0; m_udf = 0;
            q_data.delete();
        end else begin
`ifdef RF_FIFO_CTRL_ERR_EN
            m_ovf = (p && m_count == 4) || (m_ovf && !c);
            m_udf = (q && m_count == 0) || (m_udf && !c);
`endif
            if (e_push) begin q_data.push_back(d); m_wptr++; end
            if (e_pop)  begin q_exp.push_back(q_data.pop_front()); m_rptr++; end
            m_count += int'(e_push) - int'(e_pop);
            m_pv = e_pop;
        end

        @(posedge clk);
        @(negedge clk);
        chk("count", count, m_count);
        chk("full", full, m_count == 4);
        chk("empty", empty, m_count == 0);
        chk("almost_full", almost_full, m_count >= 3);
        chk("ovf", ovf, m_ovf);
        chk("udf", udf, m_udf);
        chk("pop_valid", pop_valid, m_pv);
        if (m_pv && q_exp.size() > 0) begin
            e = q_exp.pop_front();
            chk("pop_data", pop_data, e);
        end
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; push_data = '0;
        @(negedge clk);
        step(0, 8'h00, 0, 1, 0);
        step(0, 8'h00, 1, 1, 0);
        // Fill, overflow, sticky check, clear
        step(1, 8'h11, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0);
        step(1, 8'h33, 0, 0, 0);
        step(1, 8'h44, 0, 0, 0);
        step(1, 8'h99, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        // Drain back-to-back, then underflow and clear
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        // Overflow coinciding with clear keeps the flag set
        for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 0, 0, 0);
        step(1, 8'hEE, 0, 0, 1);
        // Push+pop while full, drain, push+pop while empty
        step(1, 8'h55, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);
        step(1, 8'h66, 1, 0, 1);
        step(0, 8'h00, 1, 0, 0);
        // Interleaved wrap
        for (int i = 0; i < 6; i++) begin
            step(1, 8'hC0 + 8'(i), 0, 0, 0);
            step(0, 8'h00, 1, 0, 0);
        end
        // Reset mid-run concurrent with pop
        step(1, 8'h01, 0, 0, 0);
        step(1, 8'h02, 0, 0, 0);
        step(0, 8'h00, 1, 1, 0);
        step(1, 8'h03, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(bit'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 bit'($urandom_range(0, 1)), $urandom_range(0, 40) == 0,
                 $urandom_range(0, 15) == 0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
